// File: rtl/tdm_demux16_if.sv
// Bus bundle for the 16-slot serial TDM demultiplexer: serial sample side
// (din/din_vld/sof) and parallel frame side (dout/dout_vld/sel/locked/err).
interface tdm_demux16_if #(
  parameter int NCH  = 16,
  parameter int SELW = 4
);
  logic            din;
  logic            din_vld;
  logic            sof;
  logic [NCH-1:0]  dout;
  logic            dout_vld;
  logic [SELW-1:0] sel;
  logic            locked;
  logic            err;

  // Master drives the serial samples and observes the frame side.
  modport master (
    output din, din_vld, sof,
    input  dout, dout_vld, sel, locked, err
  );

  // Slave is the demultiplexer itself.
  modport slave (
    input  din, din_vld, sof,
    output dout, dout_vld, sel, locked, err
  );
endinterface

// File: rtl/tdm_demux16.sv
// Serial TDM demultiplexer: assembles NCH successive valid samples, aligned by
// sof, into a parallel frame word with a valid pulse, lock tracking and error pulse.
module tdm_demux16 #(
  parameter int NCH  = 16,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tdm_demux16_if.slave    bus
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [SELW-1:0] LAST_SLOT = SELW'(NCH - 1);
  localparam logic [SELW-1:0] ONE_SLOT  = SELW'(1);

  state_t          state_r, state_s;
  logic [SELW-1:0] slot_r, slot_s;
  logic [NCH-1:0]  frame_r, frame_s;
  logic [NCH-1:0]  dout_r, dout_s;
  logic            dout_vld_r, dout_vld_s;
  logic            locked_r, locked_s;
  logic            err_r, err_s;

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HUNT;
      slot_r     <= {SELW{1'b0}};
      frame_r    <= {NCH{1'b0}};
      dout_r     <= {NCH{1'b0}};
      dout_vld_r <= 1'b0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_r     <= slot_s;
      frame_r    <= frame_s;
      dout_r     <= dout_s;
      dout_vld_r <= dout_vld_s;
      locked_r   <= locked_s;
      err_r      <= err_s;
    end
  end

  // Next-state logic; pulses clear by default and only accepted samples move state.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    frame_s    = frame_r;
    dout_s     = dout_r;
    dout_vld_s = 1'b0;
    locked_s   = locked_r;
    err_s      = 1'b0;

    if (bus.din_vld) begin
      case (state_r)
        HUNT: begin
          if (bus.sof) begin
            frame_s    = {NCH{1'b0}};
            frame_s[0] = bus.din;
            slot_s     = ONE_SLOT;
            state_s    = RECV;
          end else if (locked_r) begin
            err_s    = 1'b1;
            locked_s = 1'b0;
          end else begin
            slot_s = {SELW{1'b0}};
          end
        end
        RECV: begin
          if (bus.sof) begin
            // Early sof: restart the frame on this sample, never publish the partial one.
            err_s      = 1'b1;
            locked_s   = 1'b0;
            frame_s    = {NCH{1'b0}};
            frame_s[0] = bus.din;
            slot_s     = ONE_SLOT;
          end else begin
            frame_s[slot_r] = bus.din;
            if (slot_r == LAST_SLOT) begin
              dout_s     = frame_s;
              dout_vld_s = 1'b1;
              locked_s   = 1'b1;
              slot_s     = {SELW{1'b0}};
              state_s    = HUNT;
            end else begin
              slot_s = slot_r + ONE_SLOT;
            end
          end
        end
        default: begin
          state_s  = HUNT;
          slot_s   = {SELW{1'b0}};
          locked_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign bus.dout     = dout_r;
  assign bus.dout_vld = dout_vld_r;
  assign bus.sel      = slot_r;
  assign bus.locked   = locked_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16 with hand-computed frame words.
module tb_tdm_demux16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   vld_cnt;
  int   err_cnt;
  int   vld_base;
  int   err_base;

  tdm_demux16_if #(.NCH(16), .SELW(4)) bus ();

  tdm_demux16 #(.NCH(16), .SELW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.dout_vld) vld_cnt = vld_cnt + 1;
    if (bus.err)      err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs === exp_v) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // One accepted sample; returns 1 time unit after the accepting edge.
  task automatic sample(input logic b, input logic s);
    @(negedge clk);
    bus.din     = b;
    bus.sof     = s;
    bus.din_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
    bus.sof     = 1'b0;
  endtask

  // Sends slots lo..hi of word w, checking sel before each sample and the
  // published frame when slot 15 is written.
  task automatic send_bits(input logic [15:0] w, input int lo, input int hi,
                           input logic first_sof, input int maxgap);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("sel_slot%0d", i), {28'd0, bus.sel}, i);
      sample(w[i], (i == lo) ? first_sof : 1'b0);
      if (i != hi) repeat ($urandom_range(0, maxgap)) @(posedge clk);
    end
    if (hi == 15) begin
      chk("frame_vld",    {31'd0, bus.dout_vld}, 32'd1);
      chk("frame_dout",   {16'd0, bus.dout},     {16'd0, w});
      chk("frame_locked", {31'd0, bus.locked},   32'd1);
      chk("frame_sel",    {28'd0, bus.sel},      32'd0);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; vld_cnt = 0; err_cnt = 0;
    bus.din = 1'b0; bus.din_vld = 1'b0; bus.sof = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout",   {16'd0, bus.dout},     32'd0);
    chk("rst_vld",    {31'd0, bus.dout_vld}, 32'd0);
    chk("rst_sel",    {28'd0, bus.sel},      32'd0);
    chk("rst_locked", {31'd0, bus.locked},   32'd0);
    chk("rst_err",    {31'd0, bus.err},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame A5C3, pulse lasts one cycle, dout holds.
    send_bits(16'hA5C3, 0, 15, 1'b1, 0);
    @(posedge clk); #1;
    chk("a5c3_vld_pulse", {31'd0, bus.dout_vld}, 32'd0);
    chk("a5c3_hold",      {16'd0, bus.dout},     32'h0000A5C3);
    chk("a5c3_no_err",    err_cnt,               32'd0);

    // Back-to-back frames with random gaps between samples.
    vld_base = vld_cnt; err_base = err_cnt;
    send_bits(16'h1234, 0, 15, 1'b1, 3);
    send_bits(16'hFFFF, 0, 15, 1'b1, 3);
    @(posedge clk); #1;
    chk("b2b_vld_count", vld_cnt - vld_base, 32'd2);
    chk("b2b_err_count", err_cnt - err_base, 32'd0);

    // Early sof on the 6th sample; partial all-ones frame is discarded.
    send_bits(16'h001F, 0, 4, 1'b1, 1);
    sample(1'b0, 1'b1);
    chk("early_err",    {31'd0, bus.err},      32'd1);
    chk("early_locked", {31'd0, bus.locked},   32'd0);
    chk("early_sel",    {28'd0, bus.sel},      32'd1);
    chk("early_vld",    {31'd0, bus.dout_vld}, 32'd0);
    chk("early_dout",   {16'd0, bus.dout},     32'h0000FFFF);
    send_bits(16'h00F0, 1, 15, 1'b0, 1);
    chk("early_new_err", {31'd0, bus.err}, 32'd0);

    // Fresh reset, then samples without sof are dropped silently.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    err_base = err_cnt;
    for (int i = 0; i < 7; i++) sample(i[0], 1'b0);
    @(posedge clk); #1;
    chk("nosof_err",    err_cnt - err_base,  32'd0);
    chk("nosof_locked", {31'd0, bus.locked}, 32'd0);
    chk("nosof_sel",    {28'd0, bus.sel},    32'd0);
    chk("nosof_dout",   {16'd0, bus.dout},   32'd0);

    // Locked, then a non-sof sample in HUNT.
    send_bits(16'h3C5A, 0, 15, 1'b1, 0);
    err_base = err_cnt;
    sample(1'b1, 1'b0);
    chk("hunt_err",    {31'd0, bus.err},    32'd1);
    chk("hunt_locked", {31'd0, bus.locked}, 32'd0);
    @(posedge clk); #1;
    chk("hunt_err_once", err_cnt - err_base, 32'd1);
    chk("hunt_dout",     {16'd0, bus.dout},  32'h00003C5A);

    // Async reset mid-frame after slot 9.
    send_bits(16'h5A5A, 0, 15, 1'b1, 0);
    send_bits(16'hFFFF, 0, 9, 1'b1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dout",   {16'd0, bus.dout},   32'd0);
    chk("arst_sel",    {28'd0, bus.sel},    32'd0);
    chk("arst_locked", {31'd0, bus.locked}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    send_bits(16'h8001, 0, 15, 1'b1, 2);

    // sof toggling while din_vld=0 is ignored.
    err_base = err_cnt;
    send_bits(16'h6B2D, 0, 7, 1'b1, 0);
    @(negedge clk); bus.sof = 1'b1; bus.din = 1'b1;
    @(negedge clk); bus.sof = 1'b0;
    @(negedge clk); bus.sof = 1'b1;
    @(posedge clk); #1;
    bus.sof = 1'b0;
    chk("sofidle_sel", {28'd0, bus.sel},   32'd8);
    chk("sofidle_err", err_cnt - err_base, 32'd0);
    send_bits(16'h6B2D, 8, 15, 1'b0, 0);
    chk("sofidle_err_end", err_cnt - err_base, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
